// File: rtl/csi_pixel_unpacker.sv
// CSI-2 payload to pixel unpacker: reassembles 4-lane byte stream into whole pixels for flow_control.
// Optional UNPACKER_STATS_EN adds err_count_o / px_count_o statistics outputs.
module csi_pixel_unpacker #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned ACC_BYTES = 8
) (
  input  logic                     byte_clk_i,
  input  logic                     reset_n_i,
  input  logic [5:0]               data_type_i,
  input  logic                     line_start_i,
  input  logic                     line_end_i,
  input  logic [8*NUM_LANES-1:0]   payload_i,
  input  logic [NUM_LANES-1:0]     payload_valid_i,
  output logic [47:0]              byte_data_o,
  output logic [3:0]               byte_data_valid_o,
  output logic [5:0]               data_type_o,
  output logic                     line_done_o,
  output logic                     residual_err_o
`ifdef UNPACKER_STATS_EN
  ,
  output logic [15:0]              err_count_o,
  output logic [15:0]              px_count_o
`endif
);

  localparam int unsigned BUF_BYTES = ACC_BYTES + NUM_LANES;
  localparam int unsigned CW        = $clog2(BUF_BYTES + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state_q;
  cnt_t       cnt_q;
  logic [7:0] acc_q [ACC_BYTES];

  logic       active, flush, resid;
  cnt_t       base, n_in, total, nb, rem, cnt_d;
  logic [2:0] np;
  logic [5:0] type_eff;
  logic [47:0] px;
  logic [3:0] valid_d;
  logic [7:0] buf_b [BUF_BYTES];
  logic [7:0] acc_d [ACC_BYTES];

  always_comb begin
    active   = line_start_i || (state_q == ACTIVE);
    base     = line_start_i ? '0 : cnt_q;
    type_eff = line_start_i ? data_type_i : data_type_o;

    n_in = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (payload_valid_i[k] && n_in == cnt_t'(k)) n_in = n_in + cnt_t'(1);
    end
    if (!active) n_in = '0;
    total = base + n_in;

    // Merge carried bytes with this cycle's bytes, oldest at index 0
    for (int unsigned j = 0; j < BUF_BYTES; j++) buf_b[j] = '0;
    for (int unsigned j = 0; j < ACC_BYTES; j++) begin
      if (cnt_t'(j) < base) buf_b[j] = acc_q[j];
    end
    for (int unsigned j = 0; j < BUF_BYTES; j++) begin
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
        if (cnt_t'(k) < n_in && cnt_t'(j) == base + cnt_t'(k)) buf_b[j] = payload_i[8*k +: 8];
      end
    end

    px = '0;
    np = '0;
    nb = '0;
    case (type_eff)
      6'h2A: begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (cnt_t'(i) < total) begin
            px[8*i +: 8] = buf_b[i];
            np = np + 3'd1;
          end
        end
        nb = cnt_t'(np);
      end
      6'h2B: begin
        if (total >= cnt_t'(5)) begin
          for (int unsigned i = 0; i < 4; i++) px[10*i +: 10] = {buf_b[i], buf_b[4][2*i +: 2]};
          np = 3'd4;
          nb = cnt_t'(5);
        end
      end
      6'h22, 6'h1E: begin
        for (int unsigned i = 0; i < 2; i++) begin
          if (cnt_t'(2*i + 2) <= total) begin
            px[16*i +: 16] = {buf_b[2*i+1], buf_b[2*i]};
            np = np + 3'd1;
          end
        end
        nb = cnt_t'(2 * np);
      end
      6'h24: begin
        for (int unsigned i = 0; i < 2; i++) begin
          if (cnt_t'(3*i + 3) <= total) begin
            px[24*i +: 24] = {buf_b[3*i+2], buf_b[3*i+1], buf_b[3*i]};
            np = np + 3'd1;
          end
        end
        nb = cnt_t'(3 * np);
      end
      default: nb = total;
    endcase
    rem = total - nb;

    for (int unsigned j = 0; j < ACC_BYTES; j++) begin
      acc_d[j] = '0;
      for (int unsigned s = 0; s < BUF_BYTES; s++) begin
        if (s == j + 32'(nb)) acc_d[j] = buf_b[s];
      end
    end

    for (int unsigned i = 0; i < 4; i++) valid_d[i] = (3'(i) < np);

    flush = active && line_end_i;
    resid = (line_start_i && state_q == ACTIVE && cnt_q != '0) || (flush && rem != '0);
    cnt_d = (active && !line_end_i) ? rem : '0;
  end

  always_ff @(posedge byte_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      for (int unsigned j = 0; j < ACC_BYTES; j++) acc_q[j] <= '0;
      byte_data_o       <= '0;
      byte_data_valid_o <= '0;
      data_type_o       <= '0;
      line_done_o       <= 1'b0;
      residual_err_o    <= 1'b0;
    end else begin
      assert (32'(total) <= ACC_BYTES);
      state_q <= (active && !line_end_i) ? ACTIVE : IDLE;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      if (line_start_i) data_type_o <= data_type_i;
      byte_data_valid_o <= valid_d;
      if (np != '0) byte_data_o <= px;
      line_done_o    <= flush;
      residual_err_o <= resid;
    end
  end

`ifdef UNPACKER_STATS_EN
  always_ff @(posedge byte_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_count_o <= '0;
      px_count_o  <= '0;
    end else begin
      if (resid && err_count_o != '1) err_count_o <= err_count_o + 16'd1;
      if (line_start_i) px_count_o <= 16'(np);
      else if (active) px_count_o <= px_count_o + 16'(np);
    end
  end
`endif

endmodule

// File: tb/tb_csi_pixel_unpacker.sv
// Self-checking bench for csi_pixel_unpacker: directed cases plus randomized lines against a queue model.
module tb_csi_pixel_unpacker;

  logic        byte_clk_i = 1'b0;
  logic        reset_n_i;
  logic [5:0]  data_type_i;
  logic        line_start_i;
  logic        line_end_i;
  logic [31:0] payload_i;
  logic [3:0]  payload_valid_i;
  logic [47:0] byte_data_o;
  logic [3:0]  byte_data_valid_o;
  logic [5:0]  data_type_o;
  logic        line_done_o;
  logic        residual_err_o;
`ifdef UNPACKER_STATS_EN
  logic [15:0] err_count_o;
  logic [15:0] px_count_o;
`endif

  csi_pixel_unpacker #(.NUM_LANES(4), .ACC_BYTES(8)) dut (
    .byte_clk_i        (byte_clk_i),
    .reset_n_i         (reset_n_i),
    .data_type_i       (data_type_i),
    .line_start_i      (line_start_i),
    .line_end_i        (line_end_i),
    .payload_i         (payload_i),
    .payload_valid_i   (payload_valid_i),
    .byte_data_o       (byte_data_o),
    .byte_data_valid_o (byte_data_valid_o),
    .data_type_o       (data_type_o),
    .line_done_o       (line_done_o),
    .residual_err_o    (residual_err_o)
`ifdef UNPACKER_STATS_EN
    ,
    .err_count_o       (err_count_o),
    .px_count_o        (px_count_o)
`endif
  );

  always #5 byte_clk_i = ~byte_clk_i;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0]  mq[$];
  logic [5:0]  m_type;
  bit          m_active;
  logic [47:0] m_data;
  logic [3:0]  m_valid;
  bit          m_done, m_resid;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_type = '0; m_active = 0; m_data = '0; m_valid = '0; m_done = 0; m_resid = 0;
  endtask

  task automatic model_step(input logic ls, le, input logic [5:0] dt, input logic [31:0] pl,
                            input logic [3:0] pv);
    int unsigned n, np;
    logic [47:0] px;
    m_resid = 0; m_done = 0; np = 0; px = '0;
    if (ls) begin
      if (m_active && mq.size() > 0) m_resid = 1;
      mq.delete();
      m_type = dt;
      m_active = 1;
    end
    if (m_active) begin
      n = 0;
      while (n < 4 && pv[n]) n++;
      for (int k = 0; k < int'(n); k++) mq.push_back(pl[8*k +: 8]);
      case (m_type)
        6'h2A: while (np < 4 && mq.size() >= 1) begin
          px[8*np +: 8] = mq.pop_front();
          np++;
        end
        6'h2B: if (mq.size() >= 5) begin
          for (int i = 0; i < 4; i++) px[10*i +: 10] = {mq[i], 2'(mq[4] >> (2*i))};
          repeat (5) void'(mq.pop_front());
          np = 4;
        end
        6'h22, 6'h1E: while (np < 2 && mq.size() >= 2) begin
          px[16*np +: 16] = {mq[1], mq[0]};
          repeat (2) void'(mq.pop_front());
          np++;
        end
        6'h24: while (np < 2 && mq.size() >= 3) begin
          px[24*np +: 24] = {mq[2], mq[1], mq[0]};
          repeat (3) void'(mq.pop_front());
          np++;
        end
        default: mq.delete();
      endcase
      if (le) begin
        if (mq.size() > 0) m_resid = 1;
        mq.delete();
        m_done = 1;
        m_active = 0;
      end
    end
    m_valid = 4'((1 << np) - 1);
    if (np > 0) m_data = px;
  endtask

  task automatic check_all();
    chk("valid", 48'(byte_data_valid_o), 48'(m_valid));
    chk("data", byte_data_o, m_data);
    chk("dtype", 48'(data_type_o), 48'(m_type));
    chk("done", 48'(line_done_o), 48'(m_done));
    chk("resid", 48'(residual_err_o), 48'(m_resid));
  endtask

  task automatic drive(input logic ls, le, input logic [5:0] dt, input logic [31:0] pl,
                       input logic [3:0] pv);
    line_start_i = ls; line_end_i = le; data_type_i = dt; payload_i = pl; payload_valid_i = pv;
    model_step(ls, le, dt, pl, pv);
    @(posedge byte_clk_i);
    #1;
    check_all();
  endtask

  logic [5:0] types [6] = '{6'h2A, 6'h2B, 6'h22, 6'h1E, 6'h24, 6'h12};

  initial begin
    reset_n_i = 1'b0;
    line_start_i = 0; line_end_i = 0; data_type_i = '0; payload_i = '0; payload_valid_i = '0;
    model_reset();
    repeat (2) @(posedge byte_clk_i);
    #1;
    check_all();
    reset_n_i = 1'b1;

    // RAW8 single word line
    drive(1, 0, 6'h2A, 32'h44332211, 4'hF);
    chk("raw8_px", 48'(byte_data_o[31:0]), 48'h44332211);
    drive(0, 1, 6'h2A, 32'h0, 4'h0);
    chk("raw8_done", 48'(line_done_o), 48'h1);

    // RAW10 across two cycles
    drive(1, 0, 6'h2B, 32'h04030201, 4'hF);
    drive(0, 1, 6'h2B, 32'h000000E4, 4'h1);
    chk("raw10_px", 48'(byte_data_o[39:0]), 48'({10'h013, 10'h00E, 10'h009, 10'h004}));

    // RGB888 three cycles
    drive(1, 0, 6'h24, 32'h04030201, 4'hF);
    chk("rgb888_p0", 48'(byte_data_o[23:0]), 48'h030201);
    drive(0, 0, 6'h24, 32'h08070605, 4'hF);
    drive(0, 1, 6'h24, 32'h0C0B0A09, 4'hF);
    chk("rgb888_p23", byte_data_o, 48'h0C0B0A090807);
    chk("rgb888_v", 48'(byte_data_valid_o), 48'h3);

    // RGB565 ending with 3 bytes
    drive(1, 0, 6'h22, 32'h00000011, 4'h1);
    drive(0, 1, 6'h22, 32'h00003322, 4'h3);
    chk("rgb565_resid", 48'(residual_err_o), 48'h1);

    // Abort a RAW10 line with 2 bytes pending by starting a RAW8 line
    drive(1, 0, 6'h2B, 32'h00005566, 4'h3);
    drive(1, 0, 6'h2A, 32'hDDCCBBAA, 4'h3);
    chk("abort_resid", 48'(residual_err_o), 48'h1);
    chk("abort_px", 48'(byte_data_o[15:0]), 48'hBBAA);
    drive(0, 1, 6'h2A, 32'h0, 4'h0);

    // Unknown type and non-contiguous valid
    drive(1, 0, 6'h12, 32'h12345678, 4'hF);
    drive(0, 1, 6'h12, 32'h9ABCDEF0, 4'hB);

    // One-cycle line with odd RAW8 valid pattern
    drive(1, 1, 6'h2A, 32'hA1B2C3D4, 4'h5);

    // Mid-line asynchronous reset with 3 bytes buffered
    drive(1, 0, 6'h2B, 32'h00030201, 4'h7);
    #2 reset_n_i = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge byte_clk_i);
    #1 reset_n_i = 1'b1;
    drive(0, 0, 6'h2A, 32'hAABBCCDD, 4'hF);
    drive(0, 1, 6'h2A, 32'h11223344, 4'hF);

    // Randomized lines
    for (int c = 0; c < 400; c++) begin
      logic ls, le;
      ls = ($urandom_range(0, 9) == 0);
      le = ($urandom_range(0, 7) == 0);
      drive(ls, le, types[$urandom_range(0, 5)], $urandom, 4'($urandom));
    end

    line_start_i = 0; line_end_i = 0; payload_valid_i = '0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
